// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and reports one
// debounced hex keycode per physical press.
//
// Ports:
//   int_osc    in   system clock (all state updates on its rising edge)
//   reset      in   synchronous, active-high reset
//   rows[3:0]  in   row sense, active-low, asynchronous to int_osc
//   cols[3:0]  out  column drive, active-low, exactly one bit low
//   key_valid  out  one-cycle pulse when a new press is accepted
//   key_code   out  hex code of the most recently accepted key (held)
//   key_held   out  high from key_valid until release debounce completes
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 48000,
  parameter int unsigned DEBOUNCE_CNT = 960000
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       rows_meta;
  logic [3:0]       rows_s;
  logic [DIV_W-1:0] div_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       trk_row;

  logic             tick;
  logic [1:0]       col_next;
  logic             trk_high;
  logic [1:0]       low_row;

  // Legend printed on the keypad, indexed by {row, col}.
  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b0000: code = 4'h1;
      4'b0001: code = 4'h2;
      4'b0010: code = 4'h3;
      4'b0011: code = 4'hA;
      4'b0100: code = 4'h4;
      4'b0101: code = 4'h5;
      4'b0110: code = 4'h6;
      4'b0111: code = 4'hB;
      4'b1000: code = 4'h7;
      4'b1001: code = 4'h8;
      4'b1010: code = 4'h9;
      4'b1011: code = 4'hC;
      4'b1100: code = 4'hE;
      4'b1101: code = 4'h0;
      4'b1110: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Active-low one-hot column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Scan/debounce helpers derived from current state.
  always_comb begin
    tick     = (div_cnt == DIV_LAST);
    col_next = col_idx + 2'd1;
    trk_high = rows_s[trk_row];
    low_row  = 2'd3;
    if (!rows_s[0])      low_row = 2'd0;
    else if (!rows_s[1]) low_row = 2'd1;
    else if (!rows_s[2]) low_row = 2'd2;
  end

  // Synchronizer, scan FSM and registered outputs.
  always_ff @(posedge int_osc) begin
    if (reset) begin
      rows_meta <= 4'hF;
      rows_s    <= 4'hF;
      state     <= SCAN;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      col_idx   <= 2'd0;
      trk_row   <= 2'd0;
      cols      <= 4'b1110;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
    end else begin
      rows_meta <= rows;
      rows_s    <= rows_meta;
      key_valid <= 1'b0;

      case (state)
        SCAN: begin
          if (tick) begin
            div_cnt <= '0;
            if (rows_s == 4'hF) begin
              col_idx <= col_next;
              cols    <= col_drive(col_next);
            end else begin
              // Column stays put so the tracked row keeps meaning this key.
              trk_row <= low_row;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        DEBOUNCE: begin
          if (trk_high) begin
            // Aborted press: resume scanning at the next column.
            state   <= SCAN;
            div_cnt <= '0;
            col_idx <= col_next;
            cols    <= col_drive(col_next);
          end else if (deb_cnt == DEB_LAST) begin
            key_valid <= 1'b1;
            key_code  <= keymap(trk_row, col_idx);
            key_held  <= 1'b1;
            deb_cnt   <= '0;
            state     <= HELD;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        HELD: begin
          if (trk_high) begin
            deb_cnt <= '0;
            state   <= RELEASE;
          end
        end

        RELEASE: begin
          if (!trk_high) begin
            // Release bounce: back to held without a new pulse.
            state <= HELD;
          end else if (deb_cnt == DEB_LAST) begin
            key_held <= 1'b0;
            deb_cnt  <= '0;
            div_cnt  <= '0;
            state    <= SCAN;
            col_idx  <= col_next;
            cols     <= col_drive(col_next);
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule
